// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read arbiter: burst/resp encodings,
// the AR issue FSM state, and the master-index width helper.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Width of a master index; never below 1 so single-requester builds stay legal.
  function automatic int midx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to index 0. The pointer register lives in the caller.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = midx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found      = 1'b1;
        gnt[i]     = 1'b1;
        gnt_idx    = IDX_W'(i);
      end
    end
    // Wrapped pass: only reached when nothing at or above ptr is requesting.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found      = 1'b1;
        gnt[i]     = 1'b1;
        gnt_idx    = IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI read arbiter: NUM_MST masters share one AR/R port; ARID is
// extended with the master index and R beats are routed back by those bits.
// Optional per-master outstanding limit: define AXI_RD_ARB_OUTSTANDING_LIMIT_EN.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MST          = 4,
  parameter int C_AXI_ID_WIDTH   = 10,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_LEN_WIDTH  = 8,
  parameter int MAX_OUTSTANDING  = 8,
  localparam int MIDX_W = midx_w(NUM_MST),
  localparam int S_ID_W = C_AXI_ID_WIDTH + MIDX_W
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_ARESET,
  input  logic [NUM_MST*C_AXI_ID_WIDTH-1:0]   M_ARID,
  input  logic [NUM_MST*C_AXI_ADDR_WIDTH-1:0] M_ARADDR,
  input  logic [NUM_MST*C_AXI_LEN_WIDTH-1:0]  M_ARLEN,
  input  logic [NUM_MST*3-1:0]                M_ARSIZE,
  input  logic [NUM_MST*2-1:0]                M_ARBURST,
  input  logic [NUM_MST-1:0]                  M_ARVALID,
  output logic [NUM_MST-1:0]                  M_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]           M_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]         M_RDATA,
  output logic [1:0]                          M_RRESP,
  output logic                                M_RLAST,
  output logic [NUM_MST-1:0]                  M_RVALID,
  input  logic [NUM_MST-1:0]                  M_RREADY,
  output logic [S_ID_W-1:0]                   S_ARID,
  output logic [C_AXI_ADDR_WIDTH-1:0]         S_ARADDR,
  output logic [C_AXI_LEN_WIDTH-1:0]          S_ARLEN,
  output logic [2:0]                          S_ARSIZE,
  output logic [1:0]                          S_ARBURST,
  output logic                                S_ARVALID,
  input  logic                                S_ARREADY,
  input  logic [S_ID_W-1:0]                   S_RID,
  input  logic [C_AXI_DATA_WIDTH-1:0]         S_RDATA,
  input  logic [1:0]                          S_RRESP,
  input  logic                                S_RLAST,
  input  logic                                S_RVALID,
  output logic                                S_RREADY,
  output logic                                ERR_RID
);

  logic [C_AXI_ID_WIDTH-1:0]   m_id   [NUM_MST];
  logic [C_AXI_ADDR_WIDTH-1:0] m_addr [NUM_MST];
  logic [C_AXI_LEN_WIDTH-1:0]  m_len  [NUM_MST];
  logic [2:0]                  m_size [NUM_MST];
  logic [1:0]                  m_burst[NUM_MST];

  for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
    assign m_id[i]    = M_ARID[i*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
    assign m_addr[i]  = M_ARADDR[i*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
    assign m_len[i]   = M_ARLEN[i*C_AXI_LEN_WIDTH +: C_AXI_LEN_WIDTH];
    assign m_size[i]  = M_ARSIZE[i*3 +: 3];
    assign m_burst[i] = M_ARBURST[i*2 +: 2];
  end

  arb_state_e                  state, state_nxt;
  logic [MIDX_W-1:0]           ptr;
  logic [NUM_MST-1:0]          eligible;
  logic [NUM_MST-1:0]          gnt;
  logic [MIDX_W-1:0]           gnt_idx;
  logic                        gnt_any;
  logic                        take;
  logic                        ar_hs;
  logic [MIDX_W-1:0]           iss_idx;

  logic [S_ID_W-1:0]           ar_id_p1;
  logic [C_AXI_ADDR_WIDTH-1:0] ar_addr_p1;
  logic [C_AXI_LEN_WIDTH-1:0]  ar_len_p1;
  logic [2:0]                  ar_size_p1;
  logic [1:0]                  ar_burst_p1;

  logic [MIDX_W-1:0]           r_idx;
  logic                        r_in_range;

  rr_arbiter #(
    .NUM_REQ (NUM_MST),
    .IDX_W   (MIDX_W)
  ) u_rr (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) state <= IDLE;
    else            state <= state_nxt;
  end

  // Grants are suppressed while reset is held so no master sees a spurious ARREADY.
  always_comb begin
    state_nxt = state;
    M_ARREADY = '0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && !AXI_ARESET) begin
          M_ARREADY = gnt;
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (S_ARREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign S_ARVALID = (state == ISSUE);
  assign ar_hs     = S_ARVALID && S_ARREADY;
  assign iss_idx   = ar_id_p1[S_ID_W-1 -: MIDX_W];

  // Stage p0 -> p1: granted AR payload captured and held until the slave accepts.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      ptr         <= '0;
      ar_id_p1    <= '0;
      ar_addr_p1  <= '0;
      ar_len_p1   <= '0;
      ar_size_p1  <= '0;
      ar_burst_p1 <= '0;
    end else begin
      if (take) begin
        ar_id_p1    <= {gnt_idx, m_id[gnt_idx]};
        ar_addr_p1  <= m_addr[gnt_idx];
        ar_len_p1   <= m_len[gnt_idx];
        ar_size_p1  <= m_size[gnt_idx];
        ar_burst_p1 <= m_burst[gnt_idx];
      end
      if (ar_hs)
        ptr <= (iss_idx == MIDX_W'(NUM_MST - 1)) ? '0 : iss_idx + MIDX_W'(1);
    end
  end

  assign S_ARID    = ar_id_p1;
  assign S_ARADDR  = ar_addr_p1;
  assign S_ARLEN   = ar_len_p1;
  assign S_ARSIZE  = ar_size_p1;
  assign S_ARBURST = ar_burst_p1;

  assign r_idx      = S_RID[S_ID_W-1 -: MIDX_W];
  assign r_in_range = (int'(r_idx) < NUM_MST);

  // Out-of-range beats are sunk (RREADY=1) so a bad RID cannot stall the slave.
  always_comb begin
    M_RVALID = '0;
    S_RREADY = 1'b1;
    for (int i = 0; i < NUM_MST; i++) begin
      if (int'(r_idx) == i) begin
        M_RVALID[i] = S_RVALID;
        S_RREADY    = M_RREADY[i];
      end
    end
  end

  assign M_RID   = S_RID[C_AXI_ID_WIDTH-1:0];
  assign M_RDATA = S_RDATA;
  assign M_RRESP = S_RRESP;
  assign M_RLAST = S_RLAST;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET)                    ERR_RID <= 1'b0;
    else if (S_RVALID && !r_in_range)  ERR_RID <= 1'b1;
  end

`ifdef AXI_RD_ARB_OUTSTANDING_LIMIT_EN
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic r_last_hs;
  assign r_last_hs = S_RVALID && S_RREADY && S_RLAST && r_in_range;

  for (genvar i = 0; i < NUM_MST; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    assign inc = ar_hs && (iss_idx == MIDX_W'(i));
    assign dec = r_last_hs && (r_idx == MIDX_W'(i));

    // Saturating in both directions; a simultaneous issue and completion cancel.
    always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET)                           cnt <= '0;
      else if (inc && !dec && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && (cnt != '0))      cnt <= cnt - CNT_W'(1);
    end

    assign eligible[i] = M_ARVALID[i] && (cnt != CNT_MAX);
  end
`else
  logic unused_max_outstanding;
  assign unused_max_outstanding = ^32'(MAX_OUTSTANDING);
  assign eligible = M_ARVALID;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a 4-master instance for AR/R behaviour
// and a 3-master instance for out-of-range RID handling.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-master instance
  logic [39:0]  m_arid;
  logic [127:0] m_araddr;
  logic [31:0]  m_arlen;
  logic [11:0]  m_arsize;
  logic [7:0]   m_arburst;
  logic [3:0]   m_arvalid, m_arready, m_rvalid, m_rready;
  logic [9:0]   m_rid;
  logic [31:0]  m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic [11:0]  s_arid, s_rid;
  logic [31:0]  s_araddr, s_rdata;
  logic [7:0]   s_arlen;
  logic [2:0]   s_arsize;
  logic [1:0]   s_arburst, s_rresp;
  logic         s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, err_rid;

  // 3-master instance
  logic [29:0]  m3_arid;
  logic [95:0]  m3_araddr;
  logic [23:0]  m3_arlen;
  logic [8:0]   m3_arsize;
  logic [5:0]   m3_arburst;
  logic [2:0]   m3_arvalid, m3_arready, m3_rvalid, m3_rready;
  logic [9:0]   m3_rid;
  logic [31:0]  m3_rdata;
  logic [1:0]   m3_rresp;
  logic         m3_rlast;
  logic [11:0]  s3_arid, s3_rid;
  logic [31:0]  s3_araddr, s3_rdata;
  logic [7:0]   s3_arlen;
  logic [2:0]   s3_arsize;
  logic [1:0]   s3_arburst, s3_rresp;
  logic         s3_arvalid, s3_arready, s3_rlast, s3_rvalid, s3_rready, err3;

  axi_rd_arbiter #(.NUM_MST(4), .MAX_OUTSTANDING(2)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .M_ARID(m_arid), .M_ARADDR(m_araddr), .M_ARLEN(m_arlen), .M_ARSIZE(m_arsize),
    .M_ARBURST(m_arburst), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
    .M_RID(m_rid), .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RLAST(m_rlast),
    .M_RVALID(m_rvalid), .M_RREADY(m_rready),
    .S_ARID(s_arid), .S_ARADDR(s_araddr), .S_ARLEN(s_arlen), .S_ARSIZE(s_arsize),
    .S_ARBURST(s_arburst), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
    .S_RID(s_rid), .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RLAST(s_rlast),
    .S_RVALID(s_rvalid), .S_RREADY(s_rready), .ERR_RID(err_rid)
  );

  axi_rd_arbiter #(.NUM_MST(3)) dut3 (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .M_ARID(m3_arid), .M_ARADDR(m3_araddr), .M_ARLEN(m3_arlen), .M_ARSIZE(m3_arsize),
    .M_ARBURST(m3_arburst), .M_ARVALID(m3_arvalid), .M_ARREADY(m3_arready),
    .M_RID(m3_rid), .M_RDATA(m3_rdata), .M_RRESP(m3_rresp), .M_RLAST(m3_rlast),
    .M_RVALID(m3_rvalid), .M_RREADY(m3_rready),
    .S_ARID(s3_arid), .S_ARADDR(s3_araddr), .S_ARLEN(s3_arlen), .S_ARSIZE(s3_arsize),
    .S_ARBURST(s3_arburst), .S_ARVALID(s3_arvalid), .S_ARREADY(s3_arready),
    .S_RID(s3_rid), .S_RDATA(s3_rdata), .S_RRESP(s3_rresp), .S_RLAST(s3_rlast),
    .S_RVALID(s3_rvalid), .S_RREADY(s3_rready), .ERR_RID(err3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    m_arvalid  = '0;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    m_rready   = '0;
    s3_rvalid  = 1'b0;
    m3_rready  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-master ARIDs as driven below: master 2 carries 0x005 for the single-master case.
  logic [9:0]  ids   [4] = '{10'h100, 10'h101, 10'h005, 10'h103};
  logic [31:0] addrs [4] = '{32'h1000_0000, 32'h1000_0100, 32'h0000_1000, 32'h1000_0300};
  int          seq   [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_arid[i*10 +: 10]   = ids[i];
      m_araddr[i*32 +: 32] = addrs[i];
      m_arlen[i*8 +: 8]    = (i == 2) ? 8'd3 : 8'(i);
      m_arsize[i*3 +: 3]   = 3'd2;
      m_arburst[i*2 +: 2]  = 2'b01;
    end
    s_rid = '0; s_rdata = '0; s_rresp = '0;
    m3_arid = '0; m3_araddr = '0; m3_arlen = '0; m3_arsize = '0; m3_arburst = '0;
    m3_arvalid = '0; s3_arready = 1'b0; s3_rid = '0; s3_rdata = '0; s3_rresp = '0; s3_rlast = 1'b0;

    // Reset state, with requests already pending
    rst = 1'b1;
    m_arvalid = 4'hF; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
    s3_rvalid = 1'b0; m3_rready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", m_arready, 4'h0);
    chk("rst_arvalid", s_arvalid, 1'b0);
    chk("rst_arid",    s_arid,    12'h0);
    chk("rst_araddr",  s_araddr,  32'h0);
    chk("rst_err",     err_rid,   1'b0);
    chk("rst_err3",    err3,      1'b0);

    // Single master 2 request and four-beat read
    do_reset();
    s_arready = 1'b1;
    m_arvalid = 4'b0100;
    #1;
    chk("t1_grant", m_arready, 4'b0100);
    tick();
    m_arvalid = '0;
    #1;
    chk("t1_arvalid", s_arvalid, 1'b1);
    chk("t1_arid",    s_arid,    12'h805);
    chk("t1_araddr",  s_araddr,  32'h1000);
    chk("t1_arlen",   s_arlen,   8'd3);
    chk("t1_noready", m_arready, 4'b0000);
    tick();
    chk("t1_arvalid_drop", s_arvalid, 1'b0);
    m_rready = 4'b0100;
    s_rid    = 12'h805;
    s_rvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_rdata = 32'hA000 + b;
      s_rlast = (b == 3);
      #1;
      chk("t1_rvalid", m_rvalid, 4'b0100);
      chk("t1_rready", s_rready, 1'b1);
      chk("t1_rid",    m_rid,    10'h005);
      chk("t1_rdata",  m_rdata,  32'hA000 + b);
      chk("t1_rlast",  m_rlast,  (b == 3));
      tick();
    end
    m_rready = '0;
    s_rlast  = 1'b0;
    #1;
    chk("t1_backpressure", s_rready, 1'b0);
    s_rvalid = 1'b0;

    // All masters requesting: grants 0,1,2,3,0 on alternate cycles
    do_reset();
    s_arready = 1'b1;
    m_arvalid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk("t2_grant", m_arready, 4'(1) << seq[c/2]);
      end else begin
        chk("t2_issue_noready", m_arready, 4'h0);
        chk("t2_arid", s_arid, {2'(seq[c/2]), ids[seq[c/2]]});
      end
      tick();
    end

    // Slave stall: payload held, no new grant until handshake
    do_reset();
    s_arready = 1'b0;
    m_arvalid = 4'b0010;
    #1;
    chk("t3_grant", m_arready, 4'b0010);
    tick();
    m_arvalid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_valid", s_arvalid, 1'b1);
      chk("t3_hold_addr",  s_araddr,  32'h1000_0100);
      chk("t3_hold_id",    s_arid,    12'h501);
      chk("t3_no_grant",   m_arready, 4'h0);
      tick();
    end
    s_arready = 1'b1;
    tick();
    chk("t3_released", s_arvalid, 1'b0);
    chk("t3_next_grant", m_arready, 4'b1000);
    m_arvalid = '0;

    // Reset while issuing: ARVALID drops and pointer returns to 0
    do_reset();
    s_arready = 1'b1;
    m_arvalid = 4'b0001;
    #1;
    chk("t4_first", m_arready, 4'b0001);
    tick();
    m_arvalid = '0;
    tick();
    m_arvalid = 4'b0101;
    s_arready = 1'b0;
    #1;
    chk("t4_rr_from1", m_arready, 4'b0100);
    tick();
    chk("t4_issuing", s_arvalid, 1'b1);
    rst = 1'b1;
    tick();
    chk("t4_rst_drop", s_arvalid, 1'b0);
    chk("t4_rst_noready", m_arready, 4'h0);
    rst = 1'b0;
    #1;
    chk("t4_lowest_after_rst", m_arready, 4'b0001);
    m_arvalid = '0;

`ifdef AXI_RD_ARB_OUTSTANDING_LIMIT_EN
    // Outstanding limit of 2 on master 1
    do_reset();
    s_arready = 1'b1;
    m_arvalid = 4'b0010;
    #1;
    chk("t5_g1", m_arready, 4'b0010);
    tick(); tick();
    chk("t5_g2", m_arready, 4'b0010);
    tick(); tick();
    m_arvalid = 4'b1010;
    #1;
    chk("t5_masked_m3", m_arready, 4'b1000);
    tick();
    m_arvalid = 4'b0010;
    tick();
    chk("t5_still_masked", m_arready, 4'h0);
    s_rid = 12'h501; s_rlast = 1'b1; s_rvalid = 1'b1; m_rready = 4'b0010;
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("t5_unmasked", m_arready, 4'b0010);
    tick();
    s_rvalid = 1'b1;
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("t5_coincide", m_arready, 4'b0010);
    tick(); tick();
    chk("t5_full_again", m_arready, 4'h0);
    m_arvalid = '0; s_rlast = 1'b0; m_rready = '0;
`endif

    // Out-of-range master index on the 3-master instance
    do_reset();
    s3_rid    = 12'hC05;
    s3_rvalid = 1'b1;
    m3_rready = 3'b000;
    #1;
    chk("t6_sink", s3_rready, 1'b1);
    chk("t6_no_rvalid", m3_rvalid, 3'b000);
    tick();
    chk("t6_err_set", err3, 1'b1);
    s3_rvalid = 1'b0;
    repeat (3) tick();
    chk("t6_err_sticky", err3, 1'b1);
    s3_rid    = 12'h805;
    s3_rvalid = 1'b1;
    m3_rready = 3'b100;
    #1;
    chk("t6_inrange_rvalid", m3_rvalid, 3'b100);
    chk("t6_inrange_rready", s3_rready, 1'b1);
    s3_rvalid = 1'b0;
    chk("t6_main_err", err_rid, 1'b0);
    do_reset();
    chk("t6_err_cleared", err3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI read port (AR + R channels) between NUM_MST read masters.
- Round-robin arbitration on AR with a registered issue stage.
- Extends ARID with the master index; the R channel is routed back by the upper ID bits.
- Sits between the masters' AXI_vif instances and a single slave-side AXI_vif.

Parameters:
- NUM_MST, 4, number of requesting masters (2..8).
- C_AXI_ID_WIDTH, 10, master-side ID width.
- C_AXI_ADDR_WIDTH, 32, address width.
- C_AXI_DATA_WIDTH, 32, read data width.
- C_AXI_LEN_WIDTH, 8, burst length width.
- MAX_OUTSTANDING, 8, per-master outstanding read burst limit (used only with the optional feature).
- Derived: MIDX_W = $clog2(NUM_MST); S_ID_W = C_AXI_ID_WIDTH + MIDX_W.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESET  in  1  reset. One clock; reset is synchronous and active-high.
- M_ARID  in  NUM_MST*C_AXI_ID_WIDTH  flattened per-master ARID, master i at slice i.
- M_ARADDR  in  NUM_MST*C_AXI_ADDR_WIDTH  per-master ARADDR.
- M_ARLEN  in  NUM_MST*C_AXI_LEN_WIDTH  per-master ARLEN.
- M_ARSIZE  in  NUM_MST*3  per-master ARSIZE.
- M_ARBURST  in  NUM_MST*2  per-master ARBURST.
- M_ARVALID  in  NUM_MST  per-master ARVALID.
- M_ARREADY  out  NUM_MST  per-master ARREADY.
- M_RID  out  C_AXI_ID_WIDTH  broadcast RID, low bits of S_RID.
- M_RDATA  out  C_AXI_DATA_WIDTH  broadcast RDATA.
- M_RRESP  out  2  broadcast RRESP.
- M_RLAST  out  1  broadcast RLAST.
- M_RVALID  out  NUM_MST  per-master RVALID.
- M_RREADY  in  NUM_MST  per-master RREADY.
- S_ARID  out  S_ID_W  {grant index, master ARID}.
- S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST  out  matching widths  registered AR payload.
- S_ARVALID  out  1  slave ARVALID.
- S_ARREADY  in  1  slave ARREADY.
- S_RID  in  S_ID_W  slave RID.
- S_RDATA  in  C_AXI_DATA_WIDTH  slave RDATA.
- S_RRESP  in  2  slave RRESP.
- S_RLAST  in  1  slave RLAST.
- S_RVALID  in  1  slave RVALID.
- S_RREADY  out  1  slave RREADY.
- ERR_RID  out  1  sticky flag: R beat received with an out-of-range master index.

Behaviour:
- Reset values: S_ARVALID=0, all S_AR* payload=0, M_ARREADY=0, rr pointer=0, ERR_RID=0, outstanding counters=0.
- Reset mid-transaction drops S_ARVALID on the next edge; no AR is replayed.
- FSM states: IDLE, ISSUE.
- IDLE:
  - eligible = M_ARVALID (masked by the outstanding limit when the optional feature is enabled).
  - If eligible != 0: pick the first set bit searching from ptr upward, wrapping.
  - Pulse M_ARREADY[g]=1 for exactly that cycle; capture the payload with S_ARID={g[MIDX_W-1:0], ARID_g}; go to ISSUE.
  - No eligible request: stay in IDLE, M_ARREADY=0.
- ISSUE:
  - S_ARVALID=1 with payload held stable until S_ARREADY=1.
  - On handshake: ptr = (g+1) mod NUM_MST; go to IDLE.
  - M_ARREADY=0 throughout ISSUE.
- Latency: M_ARVALID to S_ARVALID is 1 cycle. Maximum throughput is one AR per 2 cycles.
- R path (combinational, no storage):
  - idx = S_RID[S_ID_W-1 -: MIDX_W].
  - M_RVALID = S_RVALID << idx; S_RREADY = M_RREADY[idx].
  - M_RID = S_RID[C_AXI_ID_WIDTH-1:0]; data, resp and last are broadcast.
- Out-of-range idx (idx >= NUM_MST, only possible when NUM_MST is not a power of 2):
  - S_RREADY=1 so the beat is dropped, no M_RVALID asserted.
  - ERR_RID set; it clears only on reset.
- A master deasserting M_ARVALID before its grant is a protocol violation; behaviour is unspecified.

Optional Feature:
- Macro: AXI_RD_ARB_OUTSTANDING_LIMIT_EN.
- Defined:
  - Per-master counter, width $clog2(MAX_OUTSTANDING+1).
  - +1 on S_ARVALID&&S_ARREADY for the issued master.
  - -1 on S_RVALID&&S_RREADY&&S_RLAST for master idx.
  - Both events on the same master in one cycle: counter unchanged.
  - A master with count==MAX_OUTSTANDING is masked from eligible.
  - Counters saturate, never wrap.
- Undefined: no counters, no masking; eligible = M_ARVALID.

Decomposition:
- Package axi_arb_pkg:
  - burst typedef (FIXED/INCR/WRAP).
  - resp constants (OKAY/EXOKAY/SLVERR/DECERR).
  - FSM state enum.
  - MIDX_W helper function.
- Sub-module rr_arbiter (NUM_REQ param):
  - Inputs: req, ptr. Outputs: gnt one-hot, gnt_idx, any.
  - Purely combinational; the pointer register lives in axi_rd_arbiter.

Test Plan:
- Single master 2, ARID=0x05, ARADDR=0x1000, ARLEN=3, S_ARREADY tied 1 -> M_ARREADY[2] pulses once; S_ARVALID 1 cycle later with S_ARID={2'd2,10'h005}. Four R beats with RID=0x805 reach only M_RVALID[2], RLAST on beat 4.
- All 4 masters valid continuously, S_ARREADY=1 -> grant order 0,1,2,3,0, one grant every 2 cycles, ptr wraps 3->0.
- S_ARREADY held 0 for 5 cycles during ISSUE -> S_ARVALID and payload stable for 5 cycles; no M_ARREADY pulse until the handshake.
- AXI_ARESET asserted in ISSUE with S_ARVALID=1 -> next edge S_ARVALID=0, ptr=0; after release the first grant goes to the lowest valid master.
- With AXI_RD_ARB_OUTSTANDING_LIMIT_EN, MAX_OUTSTANDING=2, master 1 issues 2 ARs with no RLAST returned -> master 1 masked and master 3 granted. Then RLAST for master 1 coincides with a new issue for master 1 -> count stays 2.
- NUM_MST=3, S_RID upper bits=2'b11, S_RVALID=1 -> S_RREADY=1, no M_RVALID asserted, ERR_RID=1 and stays set until reset.
